// File: rtl/booth_mult_seq.sv
// Sequential signed WIDTH x WIDTH multiplier using radix-2 Booth recoding.
// One Booth step per cycle through a WIDTH+1 bit CLA built from 4-bit slices.
module booth_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int AW = WIDTH + 1;
   localparam int NG = (AW + 3) / 4;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;

   logic [AW-1:0]       m_reg;
   logic [AW-1:0]       acc_reg;
   logic [WIDTH-1:0]    q_reg;
   logic                q1_reg;
   logic [CW-1:0]       count_reg;
   logic [2*WIDTH-1:0]  product_reg;

   logic [1:0]          booth_op;
   logic [AW-1:0]       addend;
   logic                sub;
   logic [AW-1:0]       prop;
   logic [AW-1:0]       gen;
   logic [NG-1:0]       blk_p;
   logic [NG-1:0]       blk_g;
   logic [AW-1:0]       sum;
   logic                blk_c;
   logic                bit_c;
   logic [AW-1:0]       acc_shift;
   logic [WIDTH-1:0]    q_shift;
   logic                q1_shift;
   logic                last_iter;

   // Booth recoding: 10 subtracts M (as ~M with carry-in 1), 01 adds M, else adds 0.
   always_comb begin
      booth_op = {q_reg[0], q1_reg};
      addend   = '0;
      sub      = 1'b0;
      case (booth_op)
         2'b01: addend = m_reg;
         2'b10: begin
            addend = ~m_reg;
            sub    = 1'b1;
         end
         default: addend = '0;
      endcase
   end

   assign prop = acc_reg ^ addend;
   assign gen  = acc_reg & addend;

   // Per-slice group propagate/generate; missing top bits pad as pure propagate.
   generate
      for (genvar gi = 0; gi < NG; gi++) begin : g_slice
         logic [3:0] sp;
         logic [3:0] sg;
         for (genvar bj = 0; bj < 4; bj++) begin : g_bit
            if (4 * gi + bj < AW) begin : g_live
               assign sp[bj] = prop[4*gi+bj];
               assign sg[bj] = gen[4*gi+bj];
            end else begin : g_pad
               assign sp[bj] = 1'b1;
               assign sg[bj] = 1'b0;
            end
         end
         assign blk_p[gi] = &sp;
         assign blk_g[gi] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
                          | (sp[3] & sp[2] & sp[1] & sg[0]);
      end
   endgenerate

   // Slice carry-ins come from block lookahead; carries inside a slice are local.
   always_comb begin
      sum   = '0;
      blk_c = sub;
      bit_c = 1'b0;
      for (int s = 0; s < NG; s++) begin
         bit_c = blk_c;
         for (int k = 0; k < 4; k++) begin
            if (4 * s + k < AW) begin
               sum[4*s+k] = prop[4*s+k] ^ bit_c;
               bit_c      = gen[4*s+k] | (prop[4*s+k] & bit_c);
            end
         end
         blk_c = blk_g[s] | (blk_p[s] & blk_c);
      end
   end

   assign acc_shift = {sum[AW-1], sum[AW-1:1]};
   assign q_shift   = {sum[0], q_reg[WIDTH-1:1]};
   assign q1_shift  = q_reg[0];
   assign last_iter = (count_reg == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN:  if (last_iter) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_reg == ST_IDLE);
      busy  = (state_reg == ST_RUN);
      done  = (state_reg == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_reg       <= '0;
         acc_reg     <= '0;
         q_reg       <= '0;
         q1_reg      <= 1'b0;
         count_reg   <= '0;
         product_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  m_reg     <= {a[WIDTH-1], a};
                  acc_reg   <= '0;
                  q_reg     <= b;
                  q1_reg    <= 1'b0;
                  count_reg <= '0;
               end
            end
            ST_RUN: begin
               acc_reg   <= acc_shift;
               q_reg     <= q_shift;
               q1_reg    <= q1_shift;
               count_reg <= count_reg + 1'b1;
               // Product is captured from the post-shift values of the final step.
               if (last_iter) begin
                  product_reg <= {acc_shift[WIDTH-1:0], q_shift};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: cycle-level handshake/product model
// plus directed literal cases and randomized operands.
module tb_booth_mult_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Reference model: edges elapsed since accept, pending and visible product.
   int          m_phase = 0;
   logic [63:0] m_pend  = '0;
   logic [63:0] m_prod  = '0;

   booth_mult_seq #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
      longint px;
      longint py;
      px = longint'($signed(x));
      py = longint'($signed(y));
      return 64'(px * py);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_prod  = '0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1;
            m_pend  = smul(a, b);
         end
      end else begin
         m_phase++;
         if (m_phase == 33) m_prod = m_pend;
         else if (m_phase == 34) m_phase = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (ready !== (m_phase == 0) || busy !== (m_phase >= 1 && m_phase <= 32) ||
             done !== (m_phase == 33) || product !== m_prod) begin
            errors++;
            $display("FAIL cycle_model t=%0t got rdy=%b busy=%b done=%b prod=%h exp rdy=%b busy=%b done=%b prod=%h",
                     $time, ready, busy, done, product, (m_phase == 0),
                     (m_phase >= 1 && m_phase <= 32), (m_phase == 33), m_prod);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, act, expv);
      end
   endtask

   task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                        input logic [63:0] expv, input string nm, input bit noise);
      int n;
      int nb;
      int ndone;
      int done_n;
      logic [63:0] pd;
      start = 1'b1;
      a = oa;
      b = ob;
      tick();
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      n = 0; nb = 0; ndone = 0; done_n = -1; pd = '0;
      while (!ready && n < 60) begin
         if (busy) nb++;
         if (done) begin
            ndone++;
            done_n = n;
            pd = product;
         end
         if (noise) start = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      start = 1'b0;
      chk({nm, " ready_return"}, 64'(n), 64'd33);
      chk({nm, " done_edge"}, 64'(done_n), 64'd32);
      chk({nm, " done_count"}, 64'(ndone), 64'd1);
      chk({nm, " busy_cycles"}, 64'(nb), 64'd32);
      chk({nm, " product"}, pd, expv);
      $display("op %s a=%h b=%h product=%h exp=%h", nm, oa, ob, pd, expv);
   endtask

   initial begin
      int n;
      int ndone;
      int first_ready;
      int bad;
      logic [63:0] pd;
      logic [31:0] ra;
      logic [31:0] rb;

      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      tick();
      chk_en = 1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset ready", 64'(ready), 64'd1);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset product", product, 64'd0);
      tick();

      do_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "small", 0);
      do_op(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, "neg_a", 0);
      do_op(32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, "neg_b", 0);
      do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_min", 0);
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "min_m1", 0);
      do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_max", 1);

      // Start held high through RUN and DONE: only one accept, re-accept at first IDLE.
      start = 1'b1; a = 32'd2; b = 32'd3;
      tick();
      a = 32'd9; b = 32'd9;
      n = 0; ndone = 0; first_ready = -1; pd = '0;
      while (first_ready < 0 && n < 70) begin
         if (done) begin
            ndone++;
            pd = product;
         end
         if (ready) first_ready = n;
         else begin
            tick();
            n++;
         end
      end
      chk("hs done_count", 64'(ndone), 64'd1);
      chk("hs product", pd, 64'd6);
      chk("hs first_ready", 64'(first_ready), 64'd33);
      tick();
      start = 1'b0;
      chk("hs reaccept_busy", 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      chk("hs second_product", product, 64'd81);
      $display("op handshake first=%h second=%h", pd, product);
      tick();
      tick();

      // Reset during RUN aborts the operation and clears the product.
      start = 1'b1; a = 32'd100; b = 32'd200;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst ready", 64'(ready), 64'd1);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst product", product, 64'd0);
      ndone = 0;
      repeat (40) begin
         if (done) ndone++;
         tick();
      end
      chk("midrst no_done", 64'(ndone), 64'd0);
      $display("op midreset a=%h b=%h product=%h", 32'd100, 32'd200, product);

      // Product holds through a following RUN and changes on the done cycle.
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "m1_m1", 0);
      start = 1'b1; a = 32'd5; b = 32'd5;
      tick();
      start = 1'b0;
      n = 0; bad = 0;
      while (!done && n < 60) begin
         if (product !== 64'd1) bad++;
         tick();
         n++;
      end
      chk("hold stable_run", 64'(bad), 64'd0);
      chk("hold done_edge", 64'(n), 64'd32);
      chk("hold product", product, 64'd25);
      $display("op hold a=%h b=%h product=%h", 32'd5, 32'd5, product);
      tick();
      tick();

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'h7FFF_FFFF;
            2: rb = 32'h0;
            default: ;
         endcase
         do_op(ra, rb, smul(ra, rb), "rand", 1);
      end

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
